age_matrix_alloc_selector: RTL and testbench
============================================

Name: age_matrix_alloc_selector

Overview:
Parametrised successor to the issue-queue age-matrix selector. It owns the entry-valid state, allocates free slots to up to EnqWidth enqueue requests, retires up to DeqWidth entries per cycle, and supports mask-based flush. It returns up to SelWidth oldest-first picks among ready entries. It sits between rename/dispatch and the issue-queue payload RAM, which is written at the returned slot masks.

Parameters:
EntryCount, 8, number of tracked slots (>=2)
EnqWidth, 2, enqueue request ports
DeqWidth, 2, dequeue/retire ports
SelWidth, 2, oldest-first select outputs
CntW, $clog2(EntryCount+1), derived width of the free counter

Ports:
clk  in  1  clock
rstn  in  1  asynchronous active-low reset
enq_req_i  in  EnqWidth  per-port allocation request
enq_gnt_o  out  EnqWidth  grant (combinational); enq fire = req & gnt
enq_slot_o  out  EnqWidth x EntryCount  one-hot slot allocated to each port (0 if not granted)
deq_fire_i  in  DeqWidth  per-port dequeue strobe
deq_mask_i  in  DeqWidth x EntryCount  one-hot slot to dequeue
flush_i  in  1  kill strobe
flush_mask_i  in  EntryCount  slots to kill when flush_i=1
sel_mask_i  in  EntryCount  ready entries eligible for select
result_mask_o  out  SelWidth x EntryCount  one-hot pick i, oldest first
result_vld_o  out  SelWidth  |result_mask_o[i]
oldest_mask_o  out  EntryCount  one-hot oldest valid entry
entry_vld_o  out  EntryCount  registered valid vector
free_cnt_o  out  CntW  registered count of free slots
full_o / empty_o  out  1 each  free_cnt_o==0 / free_cnt_o==EntryCount

Behaviour:
- State: vld_q[EntryCount], age_q[r][c] for r!=c. age_q[r][c]=1 means r is older than c, or c is free. Diagonal is not stored; it reads as vld_q.
- Reset (async, rstn=0): vld_q=0; all off-diagonal age_q=1; free_cnt=EntryCount; empty_o=1, full_o=0. All select outputs are 0.
- Removal mask rm = (OR over j of deq_fire_i[j] ? deq_mask_i[j] : 0) | (flush_i ? flush_mask_i : 0), ANDed with vld_q. Dequeue or flush of a free slot is ignored and does not change the count.
- Allocation works from vld_q only. Slots freed in cycle N become allocatable in N+1.
  - Enqueue port j is granted iff enq_req_i[j], !flush_i, and the number of free slots exceeds the number of requests on ports <j. Grants are therefore in-order and may be partial.
  - Granted ports take the lowest-index free slots in port order.
- Enqueue update: for new slot s on port j, row s = ~(vld_q & ~rm) with bits of slots enqueued on ports <j in the same cycle cleared. The new entry is younger than every survivor and every earlier same-cycle enqueue. vld_q[s]<=1.
- Removal update: for every r, age_q[r][c]<=1 for c in rm. vld_q[c]<=0.
- A slot cannot be both removed and enqueued in one cycle, because allocation sees only currently free slots.
- free_cnt next = free_cnt - popcount(enq fire) + popcount(rm); it saturates neither way, and a legal protocol guarantees 0..EntryCount.
- Select is combinational from registered state plus sel_mask_i, with zero latency.
  - cand_0 = sel_mask_i & vld_q.
  - Pick i = the row r in cand_i with age_q[r][c]=1 for all c in cand_i, c!=r.
  - cand_{i+1} = cand_i & ~pick_i.
  - Picks are one-hot or zero. When candidates run out, the remaining result_vld_o are 0.
- oldest_mask_o uses the same rule with cand=vld_q, and is 0 when empty.
- Same-cycle enqueue, dequeue and flush (flush_i blocks enqueue only) are all legal. Selection never sees same-cycle updates.
- flush_mask_i all-ones with flush_i returns the block to the empty state, age bits all 1, in one cycle.

Decomposition:
- Package age_sel_pkg: the entry mask typedef parametrised by EntryCount, the age-row typedef, and the popcount function. CntW is derived inside the module.
- One natural sub-module: age_oldest_pick, a combinational single-stage oldest-of-candidates. It is instanced SelWidth+1 times (SelWidth select stages plus oldest_mask_o).
- Slot allocation is a loop in the top level.

Test Plan:
- Reset, then enq_req=2'b11 for 4 cycles (8 entries) -> slot masks 0x01,0x02 then 0x04,0x08 …; full_o=1 after cycle 4; next request gets enq_gnt=00.
- Full queue, sel_mask=0xFF -> result_mask={0x02,0x01} (pick0=0x01); deq slots 0,1 -> next cycle picks 0x04,0x08, free_cnt=2.
- Enq A into slot0 and B into slot1; deq A; enq C into slot0 -> oldest_mask=0x02, and with sel_mask=0x03 pick0=0x02, pick1=0x01.
- 4 entries valid, flush_i with flush_mask=0x0A plus enq_req=01 the same cycle -> enq_gnt=0; next cycle vld=0x05, free_cnt=6, oldest unchanged when it is not flushed.
- Three free slots (0, 3, 6), enq_req=2'b11 and deq of slot 2 the same cycle -> slots 0x01 and 0x08 granted; slot 2 free only from next cycle; free_cnt 3->2.
- Assert rstn mid-traffic with entries valid -> outputs return to reset values asynchronously; first enqueue after release gets slot 0.

Source files
------------

// File: rtl/age_sel_pkg.sv
// Shared types and helpers for the age-matrix allocator/selector.
// Masks are sized for the widest supported queue; modules narrow them locally.
package age_sel_pkg;

    localparam int unsigned MaxEntryCount = 64;
    localparam int unsigned PopW          = $clog2(MaxEntryCount + 1);

    typedef logic [MaxEntryCount-1:0] entry_mask_t;
    typedef logic [MaxEntryCount-1:0] age_row_t;
    typedef logic [PopW-1:0]          pop_cnt_t;

    function automatic pop_cnt_t popcount(input entry_mask_t v);
        pop_cnt_t n;
        n = '0;
        for (int i = 0; i < MaxEntryCount; i++) begin
            n = n + pop_cnt_t'(v[i]);
        end
        return n;
    endfunction

endpackage

// File: rtl/age_oldest_pick.sv
// Single-stage oldest-of-candidates: a candidate wins when it is older than
// every other candidate. The diagonal reads as valid, so it never vetoes.
module age_oldest_pick
    import age_sel_pkg::*;
#(
    parameter int EntryCount = 8
) (
    input  logic [EntryCount-1:0]                 cand_i,
    input  logic [EntryCount-1:0][EntryCount-1:0] age_i,
    output logic [EntryCount-1:0]                 pick_o
);

    always_comb begin
        pick_o = '0;
        for (int r = 0; r < EntryCount; r++) begin
            pick_o[r] = cand_i[r] & (&(~cand_i | age_i[r]));
        end
    end

endmodule

// File: rtl/age_matrix_alloc_selector.sv
// Issue-queue slot owner: allocates free slots, retires/flushes entries and
// returns up to SelWidth oldest-first picks among ready entries.
module age_matrix_alloc_selector
    import age_sel_pkg::*;
#(
    parameter int EntryCount = 8,
    parameter int EnqWidth   = 2,
    parameter int DeqWidth   = 2,
    parameter int SelWidth   = 2,
    localparam int CntW      = $clog2(EntryCount + 1)
) (
    input  logic                                clk,
    input  logic                                rstn,
    input  logic [EnqWidth-1:0]                 enq_req_i,
    output logic [EnqWidth-1:0]                 enq_gnt_o,
    output logic [EnqWidth-1:0][EntryCount-1:0] enq_slot_o,
    input  logic [DeqWidth-1:0]                 deq_fire_i,
    input  logic [DeqWidth-1:0][EntryCount-1:0] deq_mask_i,
    input  logic                                flush_i,
    input  logic [EntryCount-1:0]               flush_mask_i,
    input  logic [EntryCount-1:0]               sel_mask_i,
    output logic [SelWidth-1:0][EntryCount-1:0] result_mask_o,
    output logic [SelWidth-1:0]                 result_vld_o,
    output logic [EntryCount-1:0]               oldest_mask_o,
    output logic [EntryCount-1:0]               entry_vld_o,
    output logic [CntW-1:0]                     free_cnt_o,
    output logic                                full_o,
    output logic                                empty_o
);

    logic [EntryCount-1:0]                 vld_q, vld_d;
    logic [EntryCount-1:0]                 rm, survive, enq_all, taken;
    // Off-diagonal age bits only: row r, column c lives at c (c<r) or c-1 (c>r).
    logic [EntryCount-1:0][EntryCount-2:0] age_q, age_d;
    logic [EntryCount-1:0][EntryCount-1:0] age_full, enq_row;
    logic [CntW-1:0]                       free_cnt_q, free_cnt_d;
    logic [SelWidth-1:0][EntryCount-1:0]   cand;

    for (genvar r = 0; r < EntryCount; r++) begin : g_row
        for (genvar c = 0; c < EntryCount; c++) begin : g_col
            if (r == c) begin : g_diag
                assign age_full[r][c] = vld_q[r];
            end else if (c < r) begin : g_lo
                assign age_full[r][c] = age_q[r][c];
                assign age_d[r][c]    = enq_all[r] ? enq_row[r][c] : (age_q[r][c] | rm[c]);
            end else begin : g_hi
                assign age_full[r][c]  = age_q[r][c-1];
                assign age_d[r][c-1]   = enq_all[r] ? enq_row[r][c] : (age_q[r][c-1] | rm[c]);
            end
        end
    end

    always_comb begin
        rm = flush_i ? flush_mask_i : '0;
        for (int j = 0; j < DeqWidth; j++) begin
            if (deq_fire_i[j]) begin
                rm = rm | deq_mask_i[j];
            end
        end
        rm = rm & vld_q;
    end

    // Grants are in port order; a port only wins if a free slot is left for it.
    always_comb begin
        taken      = '0;
        enq_gnt_o  = '0;
        enq_slot_o = '0;
        for (int j = 0; j < EnqWidth; j++) begin
            if (enq_req_i[j] && !flush_i) begin
                for (int s = 0; s < EntryCount; s++) begin
                    if (!vld_q[s] && !taken[s] && !enq_gnt_o[j]) begin
                        enq_gnt_o[j]     = 1'b1;
                        enq_slot_o[j][s] = 1'b1;
                    end
                end
                taken = taken | enq_slot_o[j];
            end
        end
    end

    always_comb begin
        survive = vld_q & ~rm;
        enq_all = '0;
        enq_row = '0;
        for (int j = 0; j < EnqWidth; j++) begin
            for (int s = 0; s < EntryCount; s++) begin
                if (enq_slot_o[j][s]) begin
                    enq_row[s] = ~survive & ~enq_all;
                end
            end
            enq_all = enq_all | enq_slot_o[j];
        end
    end

    assign vld_d      = survive | enq_all;
    assign free_cnt_d = free_cnt_q
                      - CntW'(popcount(entry_mask_t'(enq_gnt_o)))
                      + CntW'(popcount(entry_mask_t'(rm)));

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            vld_q      <= '0;
            age_q      <= '1;
            free_cnt_q <= CntW'(EntryCount);
        end else begin
            vld_q      <= vld_d;
            age_q      <= age_d;
            free_cnt_q <= free_cnt_d;
        end
    end

    assign cand[0] = sel_mask_i & vld_q;

    for (genvar i = 0; i < SelWidth; i++) begin : g_sel
        age_oldest_pick #(.EntryCount(EntryCount)) u_pick (
            .cand_i (cand[i]),
            .age_i  (age_full),
            .pick_o (result_mask_o[i])
        );
        assign result_vld_o[i] = |result_mask_o[i];
        if (i + 1 < SelWidth) begin : g_next
            assign cand[i+1] = cand[i] & ~result_mask_o[i];
        end
    end

    age_oldest_pick #(.EntryCount(EntryCount)) u_oldest (
        .cand_i (vld_q),
        .age_i  (age_full),
        .pick_o (oldest_mask_o)
    );

    assign entry_vld_o = vld_q;
    assign free_cnt_o  = free_cnt_q;
    assign full_o      = (free_cnt_q == '0);
    assign empty_o     = (free_cnt_q == CntW'(EntryCount));

endmodule

// File: tb/tb_age_matrix_alloc_selector.sv
// Directed bench for age_matrix_alloc_selector with hand-computed expectations.
module tb_age_matrix_alloc_selector;

    localparam int E  = 8;
    localparam int EW = 2;
    localparam int DW = 2;
    localparam int SW = 2;
    localparam int CW = 4;

    logic                clk = 1'b0;
    logic                rstn;
    logic [EW-1:0]       enq_req;
    logic [EW-1:0]       enq_gnt;
    logic [EW-1:0][E-1:0] enq_slot;
    logic [DW-1:0]       deq_fire;
    logic [DW-1:0][E-1:0] deq_mask;
    logic                flush;
    logic [E-1:0]        flush_mask;
    logic [E-1:0]        sel_mask;
    logic [SW-1:0][E-1:0] res_mask;
    logic [SW-1:0]       res_vld;
    logic [E-1:0]        oldest;
    logic [E-1:0]        vld;
    logic [CW-1:0]       free_cnt;
    logic                full;
    logic                empty;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    age_matrix_alloc_selector #(
        .EntryCount (E),
        .EnqWidth   (EW),
        .DeqWidth   (DW),
        .SelWidth   (SW)
    ) dut (
        .clk           (clk),
        .rstn          (rstn),
        .enq_req_i     (enq_req),
        .enq_gnt_o     (enq_gnt),
        .enq_slot_o    (enq_slot),
        .deq_fire_i    (deq_fire),
        .deq_mask_i    (deq_mask),
        .flush_i       (flush),
        .flush_mask_i  (flush_mask),
        .sel_mask_i    (sel_mask),
        .result_mask_o (res_mask),
        .result_vld_o  (res_vld),
        .oldest_mask_o (oldest),
        .entry_vld_o   (vld),
        .free_cnt_o    (free_cnt),
        .full_o        (full),
        .empty_o       (empty)
    );

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic idle();
        enq_req    = '0;
        deq_fire   = '0;
        deq_mask   = '0;
        flush      = 1'b0;
        flush_mask = '0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic flush_all();
        idle();
        flush      = 1'b1;
        flush_mask = '1;
        tick();
        idle();
        #1;
        chk("flush_all_empty", 64'(empty), 64'd1);
    endtask

    task automatic fill_pairs(input int n, input string tag);
        for (int k = 0; k < n; k++) begin
            enq_req = 2'b11;
            #1;
            chk({tag, "_gnt"},   64'(enq_gnt),     64'h3);
            chk({tag, "_slot0"}, 64'(enq_slot[0]), 64'h1 << (2 * k));
            chk({tag, "_slot1"}, 64'(enq_slot[1]), 64'h1 << (2 * k + 1));
            tick();
        end
        enq_req = '0;
    endtask

    initial begin
        rstn     = 1'b0;
        sel_mask = 8'hFF;
        idle();
        #12;
        chk("rst_vld",    64'(vld),      64'h0);
        chk("rst_free",   64'(free_cnt), 64'd8);
        chk("rst_empty",  64'(empty),    64'd1);
        chk("rst_full",   64'(full),     64'd0);
        chk("rst_oldest", 64'(oldest),   64'h0);
        chk("rst_resvld", 64'(res_vld),  64'h0);
        rstn = 1'b1;
        tick();

        // fill in pairs, then full blocks further grants
        fill_pairs(4, "fill");
        #1;
        chk("full_flag", 64'(full),     64'd1);
        chk("full_free", 64'(free_cnt), 64'd0);
        chk("full_vld",  64'(vld),      64'hFF);
        enq_req = 2'b11;
        #1;
        chk("full_gnt", 64'(enq_gnt), 64'h0);
        enq_req = '0;

        // oldest-first select, then retire two oldest
        sel_mask = 8'hFF;
        #1;
        chk("sel_p0",     64'(res_mask[0]), 64'h01);
        chk("sel_p1",     64'(res_mask[1]), 64'h02);
        chk("sel_vld",    64'(res_vld),     64'h3);
        chk("sel_oldest", 64'(oldest),      64'h01);
        deq_fire    = 2'b11;
        deq_mask[0] = 8'h01;
        deq_mask[1] = 8'h02;
        tick();
        idle();
        #1;
        chk("deq_p0",     64'(res_mask[0]), 64'h04);
        chk("deq_p1",     64'(res_mask[1]), 64'h08);
        chk("deq_free",   64'(free_cnt),    64'd2);
        chk("deq_oldest", 64'(oldest),      64'h04);
        sel_mask = 8'h02;
        #1;
        chk("runout_vld", 64'(res_vld), 64'h0);
        sel_mask = 8'h10;
        #1;
        chk("single_vld", 64'(res_vld),     64'h1);
        chk("single_p1",  64'(res_mask[1]), 64'h0);
        flush_all();

        // slot reuse: A@0, B@1, retire A, C reuses slot 0 but is younger than B
        enq_req = 2'b01;
        #1;
        chk("reuse_a", 64'(enq_slot[0]), 64'h01);
        tick();
        #1;
        chk("reuse_b", 64'(enq_slot[0]), 64'h02);
        tick();
        idle();
        deq_fire    = 2'b01;
        deq_mask[0] = 8'h01;
        tick();
        idle();
        enq_req = 2'b01;
        #1;
        chk("reuse_c", 64'(enq_slot[0]), 64'h01);
        tick();
        idle();
        sel_mask = 8'h03;
        #1;
        chk("reuse_oldest", 64'(oldest),      64'h02);
        chk("reuse_p0",     64'(res_mask[0]), 64'h02);
        chk("reuse_p1",     64'(res_mask[1]), 64'h01);
        flush_all();

        // partial flush blocks a same-cycle enqueue
        fill_pairs(2, "pf");
        flush      = 1'b1;
        flush_mask = 8'h0A;
        enq_req    = 2'b01;
        #1;
        chk("pf_gnt",  64'(enq_gnt),     64'h0);
        chk("pf_slot", 64'(enq_slot[0]), 64'h0);
        tick();
        idle();
        #1;
        chk("pf_vld",    64'(vld),      64'h05);
        chk("pf_free",   64'(free_cnt), 64'd6);
        chk("pf_oldest", 64'(oldest),   64'h01);
        flush_all();

        // free slots 0,3,6; enqueue two while retiring slot 2
        fill_pairs(4, "f2");
        deq_fire    = 2'b11;
        deq_mask[0] = 8'h01;
        deq_mask[1] = 8'h08;
        tick();
        idle();
        deq_fire    = 2'b01;
        deq_mask[0] = 8'h40;
        tick();
        idle();
        #1;
        chk("mix_free0", 64'(free_cnt), 64'd3);
        enq_req     = 2'b11;
        deq_fire    = 2'b01;
        deq_mask[0] = 8'h04;
        #1;
        chk("mix_gnt",   64'(enq_gnt),     64'h3);
        chk("mix_slot0", 64'(enq_slot[0]), 64'h01);
        chk("mix_slot1", 64'(enq_slot[1]), 64'h08);
        tick();
        idle();
        sel_mask = 8'h09;
        #1;
        chk("mix_vld",    64'(vld),         64'hBB);
        chk("mix_free1",  64'(free_cnt),    64'd2);
        chk("mix_oldest", 64'(oldest),      64'h02);
        chk("mix_p0",     64'(res_mask[0]), 64'h01);
        chk("mix_p1",     64'(res_mask[1]), 64'h08);
        enq_req = 2'b01;
        #1;
        chk("mix_slot2", 64'(enq_slot[0]), 64'h04);
        tick();
        idle();

        // asynchronous reset away from the clock edge
        sel_mask = 8'hFF;
        #3;
        rstn = 1'b0;
        #1;
        chk("arst_vld",    64'(vld),      64'h0);
        chk("arst_free",   64'(free_cnt), 64'd8);
        chk("arst_empty",  64'(empty),    64'd1);
        chk("arst_oldest", 64'(oldest),   64'h0);
        chk("arst_resvld", 64'(res_vld),  64'h0);
        #2;
        rstn = 1'b1;
        tick();
        enq_req = 2'b01;
        #1;
        chk("post_rst_slot", 64'(enq_slot[0]), 64'h01);
        tick();
        idle();
        #1;
        chk("post_rst_vld", 64'(vld), 64'h01);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
